decode_stage: RTL and testbench

- Pipelined RV32I instruction-decode stage. Generalises the single-cycle decoder (register file plus immediate generator) in three ways: parametrised data width and register-file depth, a valid/ready ID/EX output register, and load-use hazard stall with a bubble counter.
- Sits between the fetch stage and the execute stage.
- Owns the architectural register file; write-back drives it directly.

---
 rtl/decode_stage.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//
// Pipelined RV32I instruction-decode stage. Sits between fetch and execute,
// owns the architectural register file (written directly by write-back), and
// presents the decoded instruction through a valid/ready ID/EX register with
// one cycle of latency. A load in ID/EX whose destination is read by the
// incoming instruction stalls decode; if execute drains the load that cycle,
// a bubble is inserted and counted.
//
// Parameters
//   XLEN   data / immediate width (>= 32)
//   AW     register address width (1..5), register count = 2**AW
//   CNT_W  width of the saturating bubble counter
//
// Ports
//   clk, rstn            clock; synchronous active-low reset
//   in_valid/in_ready    fetch handshake
//   in_inst, in_pc       instruction word and its address
//   wb_we/wb_addr/wb_data  register-file write port (x0 writes ignored)
//   flush                kill the held and the incoming instruction
//   out_valid/out_ready  execute handshake
//   out_pc, out_rs1_data, out_rs2_data, out_imm   decoded operands
//   out_rs1, out_rs2, out_rd                      register indices
//   out_opcode, out_funct3, out_funct7, out_is_load  instruction fields
//   hazard_cnt           number of load-use bubbles inserted (saturating)
//
// Build option
//   DECODE_WB_BYPASS_EN  when defined, a write-back to a source register in
//                        the transfer cycle is forwarded into the captured
//                        operand (write-first). When undefined, the captured
//                        operand is the pre-write register content.
// -----------------------------------------------------------------------------
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             wb_we,
    input  logic [AW-1:0]    wb_addr,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_rs1_data,
    output logic [XLEN-1:0]  out_rs2_data,
    output logic [XLEN-1:0]  out_imm,
    output logic [AW-1:0]    out_rs1,
    output logic [AW-1:0]    out_rs2,
    output logic [AW-1:0]    out_rd,
    output logic [6:0]       out_opcode,
    output logic [2:0]       out_funct3,
    output logic [6:0]       out_funct7,
    output logic             out_is_load,
    output logic [CNT_W-1:0] hazard_cnt
);

    // -------------------------------------------------------------------------
    // Opcodes and immediate formats
    // -------------------------------------------------------------------------
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam int NREGS = 2 ** AW;

    typedef enum logic [2:0] {
        FMT_NONE,   // R-type and unknown opcodes: immediate is zero
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } imm_fmt_e;

    // Payload held in the ID/EX register.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [AW-1:0]   rs1;
        logic [AW-1:0]   rs2;
        logic [AW-1:0]   rd;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic            is_load;
    } idex_t;

    // -------------------------------------------------------------------------
    // Field extraction
    // -------------------------------------------------------------------------
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic [6:0]    funct7;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [AW-1:0] rd;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];
    assign funct7 = in_inst[31:25];
    // Register indices use only the low AW bits of each 5-bit field.
    assign rs1    = in_inst[15 +: AW];
    assign rs2    = in_inst[20 +: AW];
    assign rd     = in_inst[7 +: AW];

    // -------------------------------------------------------------------------
    // Opcode classification: immediate format and which sources are read
    // -------------------------------------------------------------------------
    imm_fmt_e imm_fmt;
    logic     uses_rs1;
    logic     uses_rs2;

    // NOTE: every signal assigned in always_comb gets a default on entry so
    // that no path leaves it unassigned; otherwise a latch is inferred.
    always_comb begin
        imm_fmt  = FMT_NONE;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR: imm_fmt = FMT_I;
            OP_STORE: begin
                imm_fmt  = FMT_S;
                uses_rs2 = 1'b1;
            end
            OP_BRANCH: begin
                imm_fmt  = FMT_B;
                uses_rs2 = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                imm_fmt  = FMT_U;
                uses_rs1 = 1'b0;
            end
            OP_JAL: begin
                imm_fmt  = FMT_J;
                uses_rs1 = 1'b0;
            end
            OP_REG: uses_rs2 = 1'b1;
            default: ;  // unknown opcodes pass through untouched
        endcase
    end

    // -------------------------------------------------------------------------
    // Immediate generation: build the 32-bit RV32I immediate, then sign-extend
    // from bit 31 to XLEN.
    // -------------------------------------------------------------------------
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm;

    always_comb begin
        imm32 = 32'd0;
        case (imm_fmt)
            FMT_I: imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            FMT_S: imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            FMT_B: imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                            in_inst[30:25], in_inst[11:8], 1'b0};
            FMT_U: imm32 = {in_inst[31:12], 12'd0};
            FMT_J: imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                            in_inst[20], in_inst[30:21], 1'b0};
            default: imm32 = 32'd0;
        endcase
        imm       = {XLEN{imm32[31]}};
        imm[31:0] = imm32;
    end

    // -------------------------------------------------------------------------
    // Register file
    // -------------------------------------------------------------------------
    logic [XLEN-1:0] rf [NREGS];
    logic            wb_active;

    assign wb_active = wb_we && (wb_addr != '0);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    // NOTE: the register file is reset entry by entry because architectural
    // state must read zero after reset; this forces flop storage rather than
    // a RAM macro, which is acceptable at 2**AW <= 32 entries.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NREGS; i++) begin
                rf[i] <= '0;
            end
        end else if (wb_active) begin
            rf[wb_addr] <= wb_data;
        end
    end

    // Combinational read, forced to zero for x0.
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;

`ifdef DECODE_WB_BYPASS_EN
    // Write-first: a same-cycle write-back to a source wins over the stored
    // value. wb_active already excludes x0, so x0 still reads zero.
    assign rs1_data = (wb_active && wb_addr == rs1) ? wb_data :
                      (rs1 == '0)                   ? '0      : rf[rs1];
    assign rs2_data = (wb_active && wb_addr == rs2) ? wb_data :
                      (rs2 == '0)                   ? '0      : rf[rs2];
`else
    // Read-first: the captured operand is the pre-write content; the write
    // still lands in the register file on the same edge.
    assign rs1_data = (rs1 == '0) ? '0 : rf[rs1];
    assign rs2_data = (rs2 == '0) ? '0 : rf[rs2];
`endif

    // -------------------------------------------------------------------------
    // Load-use hazard and handshake
    // -------------------------------------------------------------------------
    idex_t idex_q;
    idex_t idex_d;
    logic  hazard;
    logic  xfer;
    logic  bubble;

    // Only a real load writing a non-zero register into a source that the
    // incoming instruction actually reads can stall.
    assign hazard = out_valid && idex_q.is_load && (idex_q.rd != '0) &&
                    ((uses_rs1 && idex_q.rd == rs1) ||
                     (uses_rs2 && idex_q.rd == rs2));

    assign in_ready = rstn && !flush && !hazard && (!out_valid || out_ready);
    assign xfer     = in_valid && in_ready;
    // The load leaves for execute while the dependent instruction waits:
    // the slot behind it becomes a bubble.
    assign bubble   = in_valid && hazard && out_ready;

    always_comb begin
        idex_d          = '0;
        idex_d.pc       = in_pc;
        idex_d.rs1_data = rs1_data;
        idex_d.rs2_data = rs2_data;
        idex_d.imm      = imm;
        idex_d.rs1      = rs1;
        idex_d.rs2      = rs2;
        idex_d.rd       = rd;
        idex_d.opcode   = opcode;
        idex_d.funct3   = funct3;
        idex_d.funct7   = funct7;
        idex_d.is_load  = (opcode == OP_LOAD);
    end

    // -------------------------------------------------------------------------
    // ID/EX register. Priority: flush, transfer, bubble, drain, hold.
    // The payload only changes on a transfer or reset; a drain or bubble
    // just drops out_valid.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid  <= 1'b0;
            idex_q     <= '0;
            hazard_cnt <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            idex_q    <= idex_d;
        end else if (bubble) begin
            out_valid <= 1'b0;
            if (hazard_cnt != '1) begin
                hazard_cnt <= hazard_cnt + CNT_W'(1);
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_pc       = idex_q.pc;
    assign out_rs1_data = idex_q.rs1_data;
    assign out_rs2_data = idex_q.rs2_data;
    assign out_imm      = idex_q.imm;
    assign out_rs1      = idex_q.rs1;
    assign out_rs2      = idex_q.rs2;
    assign out_rd       = idex_q.rd;
    assign out_opcode   = idex_q.opcode;
    assign out_funct3   = idex_q.funct3;
    assign out_funct7   = idex_q.funct7;
    assign out_is_load  = idex_q.is_load;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
//
// Bench for decode_stage at default parameters (XLEN=32, AW=5, CNT_W=16).
// A table of decoded-immediate vectors, hand-written sequences for the
// multi-cycle corner cases, and a randomized phase, all checked against a
// reference model that follows the instruction-set and pipeline rules
// directly.
// -----------------------------------------------------------------------------
module tb_decode_stage;

    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rstn;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_inst;
    logic [XLEN-1:0]  in_pc;
    logic             wb_we;
    logic [AW-1:0]    wb_addr;
    logic [XLEN-1:0]  wb_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_pc;
    logic [XLEN-1:0]  out_rs1_data;
    logic [XLEN-1:0]  out_rs2_data;
    logic [XLEN-1:0]  out_imm;
    logic [AW-1:0]    out_rs1;
    logic [AW-1:0]    out_rs2;
    logic [AW-1:0]    out_rd;
    logic [6:0]       out_opcode;
    logic [2:0]       out_funct3;
    logic [6:0]       out_funct7;
    logic             out_is_load;
    logic [CNT_W-1:0] hazard_cnt;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(XLEN), .AW(AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rs1_data(out_rs1_data),
        .out_rs2_data(out_rs2_data), .out_imm(out_imm),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_opcode(out_opcode), .out_funct3(out_funct3),
        .out_funct7(out_funct7), .out_is_load(out_is_load),
        .hazard_cnt(hazard_cnt)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    logic [31:0] m_rf [32];
    logic        m_valid;
    logic [31:0] m_pc, m_rs1d, m_rs2d, m_imm;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [6:0]  m_op, m_f7;
    logic [2:0]  m_f3;
    logic        m_ld;
    int          m_cnt;

    function automatic logic reads_rs1(input logic [6:0] op);
        return !(op inside {7'h37, 7'h17, 7'h6F});
    endfunction

    function automatic logic reads_rs2(input logic [6:0] op);
        return op inside {7'h33, 7'h23, 7'h63};
    endfunction

    // Immediate value computed arithmetically from the format definitions.
    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        int v;
        case (i[6:0])
            7'h03, 7'h13, 7'h67: v = $signed(i) >>> 20;
            7'h23: v = (($signed(i) >>> 25) * 32) + int'(i[11:7]);
            7'h63: v = (i[31] ? -4096 : 0) + int'(i[7]) * 2048
                       + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
            7'h37, 7'h17: v = int'(i & 32'hFFFFF000);
            7'h6F: v = (i[31] ? -1048576 : 0) + int'(i[19:12]) * 4096
                       + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef DECODE_WB_BYPASS_EN
        if (wb_we && wb_addr == a) return wb_data;
`endif
        return m_rf[a];
    endfunction

    function automatic logic ref_hazard();
        if (!(m_valid && m_ld && m_rd != 5'd0)) return 1'b0;
        return (reads_rs1(in_inst[6:0]) && m_rd == in_inst[19:15]) ||
               (reads_rs2(in_inst[6:0]) && m_rd == in_inst[24:20]);
    endfunction

    function automatic logic ref_ready();
        return rstn && !flush && !ref_hazard() && (!m_valid || out_ready);
    endfunction

    // Advance the model across one rising edge using the current inputs.
    task automatic model_edge();
        logic rdy, hz;
        rdy = ref_ready();
        hz  = ref_hazard();
        if (!rstn) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
            m_valid = 0; m_pc = 0; m_rs1d = 0; m_rs2d = 0; m_imm = 0;
            m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_op = 0; m_f3 = 0; m_f7 = 0;
            m_ld = 0; m_cnt = 0;
        end else begin
            if (flush) begin
                m_valid = 0;
            end else if (in_valid && rdy) begin
                m_valid = 1;
                m_pc    = in_pc;
                m_rs1d  = ref_read(in_inst[19:15]);
                m_rs2d  = ref_read(in_inst[24:20]);
                m_imm   = ref_imm(in_inst);
                m_rs1   = in_inst[19:15];
                m_rs2   = in_inst[24:20];
                m_rd    = in_inst[11:7];
                m_op    = in_inst[6:0];
                m_f3    = in_inst[14:12];
                m_f7    = in_inst[31:25];
                m_ld    = (in_inst[6:0] == 7'h03);
            end else if (in_valid && hz && out_ready) begin
                m_valid = 0;
                if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
            end else if (out_ready) begin
                m_valid = 0;
            end
            if (wb_we && wb_addr != 5'd0) m_rf[wb_addr] = wb_data;
        end
    endtask

    task automatic compare_all();
        check("out_valid", out_valid, m_valid);
        check("out_pc", out_pc, m_pc);
        check("out_rs1_data", out_rs1_data, m_rs1d);
        check("out_rs2_data", out_rs2_data, m_rs2d);
        check("out_imm", out_imm, m_imm);
        check("out_rs1", out_rs1, m_rs1);
        check("out_rs2", out_rs2, m_rs2);
        check("out_rd", out_rd, m_rd);
        check("out_opcode", out_opcode, m_op);
        check("out_funct3", out_funct3, m_f3);
        check("out_funct7", out_funct7, m_f7);
        check("out_is_load", out_is_load, m_ld);
        check("hazard_cnt", hazard_cnt, 64'(m_cnt));
    endtask

    // One clock: check in_ready against the model before the edge, advance
    // the model, then compare the registered outputs after the edge.
    task automatic tick();
        #1;
        check("in_ready", in_ready, ref_ready());
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 10))
            0: w[6:0] = 7'h03;  1: w[6:0] = 7'h13;  2: w[6:0] = 7'h23;
            3: w[6:0] = 7'h33;  4: w[6:0] = 7'h37;  5: w[6:0] = 7'h17;
            6: w[6:0] = 7'h6F;  7: w[6:0] = 7'h67;  8: w[6:0] = 7'h63;
            9: w[6:0] = 7'h03;  default: w[6:0] = 7'h0B;
        endcase
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    // -------------------------------------------------------------------------
    // Decode vector table
    // -------------------------------------------------------------------------
    typedef struct {
        logic [31:0] inst;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [6:0]  f7;
        logic        ld;
    } vec_t;

    localparam int NV = 13;
    vec_t vec [NV];

    initial begin
        logic [31:0] held_pc;

        vec[0]  = '{32'hFE000EE3, 32'hFFFFFFFC, 5'd29, 7'h7F, 1'b0}; // BEQ -4
        vec[1]  = '{32'hABCDE0B7, 32'hABCDE000, 5'd1,  7'h55, 1'b0}; // LUI
        vec[2]  = '{32'h7E202FA3, 32'h000007FF, 5'd31, 7'h3F, 1'b0}; // SW 0x7FF
        vec[3]  = '{32'h00138113, 32'h00000001, 5'd2,  7'h00, 1'b0}; // ADDI +1
        vec[4]  = '{32'hFFF00093, 32'hFFFFFFFF, 5'd1,  7'h7F, 1'b0}; // ADDI -1
        vec[5]  = '{32'h001000EF, 32'h00000800, 5'd1,  7'h00, 1'b0}; // JAL +2048
        vec[6]  = '{32'hFFFFF06F, 32'hFFFFFFFE, 5'd0,  7'h7F, 1'b0}; // JAL -2
        vec[7]  = '{32'h80000197, 32'h80000000, 5'd3,  7'h40, 1'b0}; // AUIPC
        vec[8]  = '{32'h000180B3, 32'h00000000, 5'd1,  7'h00, 1'b0}; // ADD
        vec[9]  = '{32'hFF008067, 32'hFFFFFFF0, 5'd0,  7'h7F, 1'b0}; // JALR -16
        vec[10] = '{32'h407302B3, 32'h00000000, 5'd5,  7'h20, 1'b0}; // SUB
        vec[11] = '{32'h1234567F, 32'h00000000, 5'd12, 7'h09, 1'b0}; // unknown
        vec[12] = '{32'h00802203, 32'h00000008, 5'd4,  7'h00, 1'b1}; // LW 8

        rstn = 0; in_valid = 0; in_inst = 0; in_pc = 0; flush = 0;
        wb_we = 0; wb_addr = 0; wb_data = 0; out_ready = 0;

        // Reset state
        tick();
        tick();
        check("reset out_valid", out_valid, 0);
        check("reset hazard_cnt", hazard_cnt, 0);
        check("reset out_imm", out_imm, 0);
        check("reset out_pc", out_pc, 0);
        rstn = 1;

        // Table-driven decode, back to back
        in_valid = 1; out_ready = 1;
        for (int i = 0; i < NV; i++) begin
            in_inst = vec[i].inst;
            in_pc   = 32'h1000 + 32'(i * 4);
            tick();
            check("vec out_valid", out_valid, 1);
            check("vec out_imm", out_imm, vec[i].imm);
            check("vec out_rd", out_rd, vec[i].rd);
            check("vec out_funct7", out_funct7, vec[i].f7);
            check("vec out_is_load", out_is_load, vec[i].ld);
            check("vec out_pc", out_pc, 32'h1000 + 32'(i * 4));
        end
        in_valid = 0;
        tick();

        // x0 writes ignored, x3 readable
        wb_we = 1; wb_addr = 3; wb_data = 32'h1234; tick();
        wb_addr = 0; wb_data = 32'hFFFF; tick();
        wb_we = 0;
        in_valid = 1; in_inst = 32'h000180B3; tick();   // ADD x1,x3,x0
        check("add rs1_data", out_rs1_data, 32'h1234);
        check("add rs2_data", out_rs2_data, 0);
        check("add imm", out_imm, 0);

        // Load-use with a real destination: one bubble
        in_inst = 32'h00802203; tick();                 // LW x4,8(x0)
        in_inst = 32'h001202B3;                         // ADD x5,x4,x1
        #1 check("hazard in_ready", in_ready, 0);
        tick();
        check("bubble out_valid", out_valid, 0);
        check("bubble hazard_cnt", hazard_cnt, 1);
        check("after bubble in_ready", in_ready, 1);
        tick();
        check("add issues out_valid", out_valid, 1);
        check("add issues out_rd", out_rd, 5);

        // Load to x0: no bubble
        in_inst = 32'h00802003; tick();                 // LW x0,8(x0)
        in_inst = 32'h001002B3;                         // ADD x5,x0,x1
        #1 check("x0 load in_ready", in_ready, 1);
        tick();
        check("x0 load no bubble", out_valid, 1);
        check("x0 load hazard_cnt", hazard_cnt, 1);

        // Backpressure: three cycles, outputs frozen
        held_pc = out_pc;
        out_ready = 0; in_inst = 32'h00138113; in_pc = 32'hCAFE0000;
        for (int i = 0; i < 3; i++) begin
            #1 check("stall in_ready", in_ready, 0);
            tick();
            check("stall out_valid", out_valid, 1);
            check("stall out_pc", out_pc, held_pc);
            check("stall out_rd", out_rd, 5);
        end

        // Flush kills the held and the incoming instruction
        flush = 1; tick();
        check("flush out_valid", out_valid, 0);
        flush = 0; in_valid = 0; out_ready = 1; tick();
        check("flush dropped", out_valid, 0);

        // Same-cycle write-back vs. operand capture
        wb_we = 1; wb_addr = 7; wb_data = 32'h11; tick();
        wb_data = 32'h55; in_valid = 1; in_inst = 32'h00138113; tick();
`ifdef DECODE_WB_BYPASS_EN
        check("bypass rs1_data", out_rs1_data, 32'h55);
`else
        check("no-bypass rs1_data", out_rs1_data, 32'h11);
`endif
        wb_we = 0; tick();
        check("x7 after write", out_rs1_data, 32'h55);

        // Randomized phase
        for (int c = 0; c < 2000; c++) begin
            rstn      = ($urandom_range(0, 199) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_inst   = rand_inst();
            in_pc     = $urandom;
            wb_we     = $urandom_range(0, 1) == 1;
            wb_addr   = 5'($urandom_range(0, 7));
            wb_data   = $urandom;
            tick();
        end

        // Reset mid-stream
        rstn = 1; flush = 0; wb_we = 1; wb_addr = 5; wb_data = 32'hDEAD;
        in_valid = 0; out_ready = 1; tick();
        wb_we = 0; in_valid = 1; in_inst = 32'h00138113; tick();
        in_inst = 32'h00802203; tick();                 // LW x4
        in_inst = 32'h001202B3; tick();                 // bubble
        in_valid = 1; tick();                           // ADD issues
        out_ready = 0; in_valid = 0; tick();
        check("pre-reset out_valid", out_valid, 1);
        rstn = 0; tick();
        check("mid reset out_valid", out_valid, 0);
        check("mid reset hazard_cnt", hazard_cnt, 0);
        rstn = 1; out_ready = 1; in_valid = 1;
        in_inst = 32'h00028113; tick();                 // ADDI x2,x5,0
        check("x5 after reset", out_rs1_data, 0);
        check("post reset out_valid", out_valid, 1);
        in_valid = 0; tick();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
